// File: rtl/shifter_right_seq.sv
// Multi-cycle right shifter/rotator: resolves one shift-amount bit per clock,
// so a single conditional-shift stage is reused across SHFT_BITS cycles.
module shifter_right_seq #(
  parameter int WIDTH     = 32,
  parameter int SHFT_BITS = 5
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     in_i,
  input  logic [SHFT_BITS-1:0] shft_i,
  input  logic [1:0]           mode_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WIDTH-1:0]     out_o
);

  localparam int KW = (SHFT_BITS > 1) ? $clog2(SHFT_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b10;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [SHFT_BITS-1:0] shft_q, shft_d;
  logic [1:0]           mode_q, mode_d;
  logic                 sign_q, sign_d;
  logic [KW-1:0]        k_q, k_d;

  logic [WIDTH-1:0]     fill;
  logic [2*WIDTH-1:0]   cat;
  logic [SHFT_BITS-1:0] amt;
  logic [WIDTH-1:0]     stage_val;
  logic                 accept;

  // The upper half of {fill, work} supplies the vacated MSBs for every mode.
  always_comb begin
    if (mode_q == MODE_ROT)      fill = work_q;
    else if (mode_q == MODE_ARI) fill = {WIDTH{sign_q}};
    else                         fill = '0;
    amt       = SHFT_BITS'(1) << k_q;
    cat       = {fill, work_q} >> amt;
    stage_val = shft_q[k_q] ? cat[WIDTH-1:0] : work_q;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    shft_d  = shft_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    k_d     = k_q;
    accept  = 1'b0;

    case (state_q)
      IDLE:   accept = start_i;
      SHIFT: begin
        work_d = stage_val;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(SHFT_BITS - 1)) begin
          out_d   = stage_val;
          k_d     = '0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        accept  = start_i;
      end
      default: state_d = IDLE;
    endcase

    // A request in the DONE cycle is taken just like one from IDLE.
    if (accept) begin
      work_d  = in_i;
      shft_d  = shft_i;
      mode_d  = mode_i;
      sign_d  = in_i[WIDTH-1];
      k_d     = '0;
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      shft_q  <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
      shft_q  <= shft_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      k_q     <= k_d;
    end
  end

  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == FINISH);
  assign out_o  = out_q;

endmodule

// File: tb/tb_shifter_right_seq.sv
// Self-checking bench for shifter_right_seq: directed vector table, multi-cycle
// corner sequences and randomized requests checked against a behavioural model.
module tb_shifter_right_seq;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_v = '0;
  logic [4:0]  sh = '0;
  logic [1:0]  md = '0;
  logic        busy, done;
  logic [31:0] out;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_out = '0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  shifter_right_seq #(.WIDTH(32), .SHFT_BITS(5)) dut (
    .clk_i   (clk),
    .n_rst_i (n_rst),
    .start_i (start),
    .in_i    (in_v),
    .shft_i  (sh),
    .mode_i  (md),
    .busy_o  (busy),
    .done_o  (done),
    .out_o   (out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] x, input int n, input logic [1:0] m);
    case (m)
      2'b00:   return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
      2'b10:   return $signed(x) >>> n;
      default: return x >> n;
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Drive a request now (caller is away from the edge) and scramble inputs afterwards.
  task automatic drive_req(input logic [31:0] a, input logic [4:0] s, input logic [1:0] m);
    in_v  = a;
    sh    = s;
    md    = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_v  = $urandom;
    sh    = 5'($urandom);
    md    = 2'($urandom);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [4:0] s, input logic [1:0] m);
    @(negedge clk);
    drive_req(a, s, m);
  endtask

  task automatic expect_done(input logic [31:0] exp, input string name, input int busy_exp);
    int busy_cnt = 0;
    bit found = 1'b0;
    bit stable = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (out !== last_out) stable = 1'b0;
      end
    end
    chk(found, {name, " done_seen"}, 32'(found), 32'd1);
    chk(busy_cnt == busy_exp, {name, " busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
    chk(stable, {name, " out_stable_while_busy"}, out, last_out);
    chk(!(busy && done), {name, " busy_with_done"}, 32'(busy), 32'd0);
    chk(out === exp, {name, " out"}, out, exp);
    last_out = exp;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit quiet = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    chk(quiet, {name, " no_activity"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0001, 5'd1,  2'b00, 32'hC000_0000};
    vecs[1] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
    vecs[2] = '{32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000};
    vecs[3] = '{32'h7FFF_FFF0, 5'd4,  2'b10, 32'h07FF_FFFF};
    vecs[4] = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF};
    vecs[5] = '{32'h8000_0000, 5'd4,  2'b11, 32'h0800_0000};
    vecs[6] = '{32'h1234_5678, 5'd16, 2'b00, 32'h5678_1234};
    vecs[7] = '{32'hFFFF_FFFF, 5'd31, 2'b10, 32'hFFFF_FFFF};
    vecs[8] = '{32'h0000_0001, 5'd31, 2'b00, 32'h0000_0002};
    vecs[9] = '{32'hF0F0_0000, 5'd20, 2'b10, 32'hFFFF_FF0F};

    // Reset state
    #1;
    chk(out === 32'd0, "reset out", out, 32'd0);
    chk(busy === 1'b0, "reset busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "reset done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    expect_quiet("idle_after_reset", 3);

    // Directed table
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].s, vecs[i].m);
      expect_done(vecs[i].exp, $sformatf("vec%0d", i), 5);
      expect_quiet($sformatf("vec%0d_after", i), 1);
    end

    // Back-to-back: START held in the DONE cycle
    start_op(32'hDEAD_BEEF, 5'd0, 2'b00);
    expect_done(32'hDEAD_BEEF, "b2b_first", 5);
    drive_req(32'h0000_0100, 5'd8, 2'b01);
    expect_done(32'h0000_0001, "b2b_second", 5);
    expect_quiet("b2b_after", 2);

    // START while busy is ignored
    start_op(32'h0000_F000, 5'd12, 2'b01);
    @(negedge clk);
    @(negedge clk);
    drive_req(32'hFFFF_FFFF, 5'd0, 2'b00);
    expect_done(32'h0000_000F, "ignored_start", 3);
    expect_quiet("ignored_no_second_done", 10);

    // Asynchronous reset in the middle of an operation
    start_op(32'h1234_5678, 5'd8, 2'b01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk(out === 32'd0, "midreset out", out, 32'd0);
    chk(busy === 1'b0, "midreset busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "midreset done", 32'(done), 32'd0);
    last_out = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    expect_quiet("midreset_no_done", 10);
    start_op(32'h8000_0001, 5'd1, 2'b00);
    expect_done(32'hC000_0000, "after_reset", 5);

    // Randomized requests against the model, some back-to-back
    begin
      bit b2b = 1'b0;
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        logic [4:0]  s;
        logic [1:0]  m;
        a = $urandom;
        s = 5'($urandom);
        m = 2'($urandom);
        if (b2b) drive_req(a, s, m);
        else start_op(a, s, m);
        expect_done(model(a, int'(s), m), $sformatf("rand%0d", i), 5);
        b2b = 1'($urandom_range(0, 1));
      end
    end
    expect_quiet("final_idle", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
